sc_reg_responder: RTL and testbench

- Slave (responder) end of the slow-control bus driven by the SC decoder/controller.
- Decodes sc_frame/sc_op/sc_wr transactions addressed to its port into a 32-bit register file.
- Returns sc_ack with sc_rply_data/sc_rply_error to the initiator, and exposes the writable registers as configuration outputs to the rest of the FPGA.
- Multiple responders share the bus; each answers only its own sc_port value.

---
 rtl/sc_reg_responder.sv | 195 +++++++++++++++++++
 tb/tb_sc_reg_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_reg_responder.sv
// Slow-control bus responder: decodes framed ops on its port into a
// 32-bit register file and acknowledges with reply data and error code.
module sc_reg_responder #(
  parameter logic [15:0] MY_PORT  = 16'h0001,
  parameter int          NREGS    = 16,
  parameter int          ACK_LAT  = 2,
  parameter logic [31:0] ID_VALUE = 32'h5C0D_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           sc_port,
  input  logic [31:0]           sc_addr,
  input  logic [31:0]           sc_subaddr,
  input  logic [31:0]           sc_data,
  input  logic                  sc_wr,
  input  logic                  sc_op,
  input  logic                  sc_frame,
  output logic                  sc_ack,
  output logic [31:0]           sc_rply_data,
  output logic [31:0]           sc_rply_error,
  input  logic [31:0]           sts_in,
  output logic [NREGS*32-1:0]   cfg_regs,
  output logic                  cfg_wr_strobe,
  output logic [7:0]            cfg_wr_addr
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t state, state_nx;

  logic        op_q;
  logic [31:0] addr_q;
  logic [31:0] sub_q;
  logic [31:0] data_q;
  logic        wr_q;
  logic [7:0]  wcnt;
  logic [31:0] trans_cnt;
  logic [31:0] err_q;
  logic [31:0] rd_q;
  logic        wr_ok_q;
  logic [31:0] mem [NREGS];

  logic [31:0]   err_c;
  logic [31:0]   rd_val;
  logic [31:0]   rd_c;
  logic          wr_ok_c;
  logic          start;
  logic          go_ack;
  logic          commit;
  logic [AW-1:0] idx;

  assign idx   = addr_q[AW-1:0];
  assign start = sc_op && !op_q && sc_frame
              && (sc_port == MY_PORT);

  always_comb begin
    err_c = 32'h0;
    if (sub_q != 32'h0)
      err_c = 32'h3;
    else if (addr_q >= 32'(NREGS))
      err_c = 32'h1;
    else if (wr_q && (addr_q < 32'd3))
      err_c = 32'h2;
  end

  always_comb begin
    rd_val = mem[idx];
    if (addr_q == 32'd0)
      rd_val = ID_VALUE;
    else if (addr_q == 32'd1)
      rd_val = sts_in;
    else if (addr_q == 32'd2)
      rd_val = trans_cnt;
  end

  assign rd_c    = ((err_c == 32'h0) && !wr_q) ? rd_val : 32'h0;
  assign wr_ok_c = (err_c == 32'h0) && wr_q;

  assign go_ack = sc_frame
    && (((state == S_DECODE) && (ACK_LAT == 0))
     || ((state == S_WAIT) && (wcnt == 8'd1)));

  // Write lands on ACK entry so an abort during WAIT discards it.
  assign commit = go_ack
    && ((state == S_DECODE) ? wr_ok_c : wr_ok_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nx = S_DECODE;
      S_DECODE:
        if (!sc_frame)
          state_nx = S_IDLE;
        else if (ACK_LAT == 0)
          state_nx = S_ACK;
        else
          state_nx = S_WAIT;
      S_WAIT:
        if (!sc_frame)
          state_nx = S_IDLE;
        else if (wcnt == 8'd1)
          state_nx = S_ACK;
      S_ACK:
        state_nx = S_RELEASE;
      S_RELEASE:
        if (!sc_op || !sc_frame)
          state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sc_ack = (state == S_ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= 1'b0;
      addr_q        <= '0;
      sub_q         <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      wcnt          <= '0;
      trans_cnt     <= '0;
      err_q         <= '0;
      rd_q          <= '0;
      wr_ok_q       <= 1'b0;
      sc_rply_data  <= '0;
      sc_rply_error <= '0;
      cfg_wr_strobe <= 1'b0;
      cfg_wr_addr   <= '0;
      for (int k = 0; k < NREGS; k++)
        mem[k] <= '0;
    end else begin
      op_q          <= sc_op;
      cfg_wr_strobe <= commit;
      if ((state == S_IDLE) && start) begin
        addr_q <= sc_addr;
        sub_q  <= sc_subaddr;
        data_q <= sc_data;
        wr_q   <= sc_wr;
      end
      if (state == S_DECODE) begin
        err_q   <= err_c;
        rd_q    <= rd_c;
        wr_ok_q <= wr_ok_c;
        wcnt    <= 8'(ACK_LAT);
      end else if ((state == S_WAIT) && (wcnt != 8'd0)) begin
        wcnt <= wcnt - 8'd1;
      end
      if (go_ack) begin
        sc_rply_data  <= (state == S_DECODE) ? rd_c : rd_q;
        sc_rply_error <= (state == S_DECODE) ? err_c : err_q;
        trans_cnt     <= trans_cnt + 32'd1;
      end
      if (commit) begin
        mem[idx]    <= data_q;
        cfg_wr_addr <= addr_q[7:0];
      end
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (k == 0)
        cfg_regs[32*k +: 32] = ID_VALUE;
      else if (k == 1)
        cfg_regs[32*k +: 32] = sts_in;
      else if (k == 2)
        cfg_regs[32*k +: 32] = trans_cnt;
      else
        cfg_regs[32*k +: 32] = mem[k];
    end
  end

endmodule

// File: tb/tb_sc_reg_responder.sv
// Scoreboard bench for sc_reg_responder: directed and random
// transactions checked against a register-map reference model.
module tb_sc_reg_responder;

  localparam logic [15:0] MY_PORT  = 16'h0001;
  localparam int          NREGS    = 16;
  localparam int          ACK_LAT  = 2;
  localparam logic [31:0] ID_VALUE = 32'h5C0D_0001;

  logic                clk = 1'b0;
  logic                rst;
  logic [15:0]         sc_port;
  logic [31:0]         sc_addr;
  logic [31:0]         sc_subaddr;
  logic [31:0]         sc_data;
  logic                sc_wr;
  logic                sc_op;
  logic                sc_frame;
  logic                sc_ack;
  logic [31:0]         sc_rply_data;
  logic [31:0]         sc_rply_error;
  logic [31:0]         sts_in;
  logic [NREGS*32-1:0] cfg_regs;
  logic                cfg_wr_strobe;
  logic [7:0]          cfg_wr_addr;

  sc_reg_responder #(
    .MY_PORT (MY_PORT),
    .NREGS   (NREGS),
    .ACK_LAT (ACK_LAT),
    .ID_VALUE(ID_VALUE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sc_port      (sc_port),
    .sc_addr      (sc_addr),
    .sc_subaddr   (sc_subaddr),
    .sc_data      (sc_data),
    .sc_wr        (sc_wr),
    .sc_op        (sc_op),
    .sc_frame     (sc_frame),
    .sc_ack       (sc_ack),
    .sc_rply_data (sc_rply_data),
    .sc_rply_error(sc_rply_error),
    .sts_in       (sts_in),
    .cfg_regs     (cfg_regs),
    .cfg_wr_strobe(cfg_wr_strobe),
    .cfg_wr_addr  (cfg_wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] err;
    logic        strobe;
    logic [7:0]  waddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [NREGS];
  logic [31:0] mdl_cnt;
  int          acks;
  int          passed;
  int          total;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_regs(string tag);
    chk({tag, "_id"}, cfg_regs[31:0], ID_VALUE);
    chk({tag, "_sts"}, cfg_regs[63:32], sts_in);
    chk({tag, "_cnt"}, cfg_regs[95:64], mdl_cnt);
    for (int k = 3; k < NREGS; k++)
      chk($sformatf("%s_reg%0d", tag, k), cfg_regs[32*k +: 32], mdl_mem[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++)
      mdl_mem[k] = '0;
    mdl_cnt = '0;
  endtask

  always @(negedge clk) begin
    if (sc_ack) begin
      acks++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got ack with data %h, none expected",
                 sc_rply_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rply_data", sc_rply_data, e.rdata);
        chk("rply_error", sc_rply_error, e.err);
        chk("wr_strobe", 32'(cfg_wr_strobe), 32'(e.strobe));
        if (e.strobe)
          chk("wr_addr", 32'(cfg_wr_addr), 32'(e.waddr));
        chk("ack_cnt", cfg_regs[95:64], e.cnt);
        check_regs("ack");
      end
    end else if (cfg_wr_strobe) begin
      chk("stray_strobe", 32'(cfg_wr_strobe), 32'h0);
    end
  end

  // mode: 0 normal, 1 foreign port, 2 frame abort in WAIT, 3 reset in WAIT
  task automatic do_op(input logic [15:0] port, input logic [31:0] addr,
                       input logic [31:0] sub, input logic [31:0] data,
                       input logic wr, input int mode);
    exp_t        e;
    logic [31:0] err;
    logic [31:0] rdata;
    int          acks0;
    int          k;
    bit          seen;
    if (sub != 0)                 err = 32'h3;
    else if (addr >= NREGS)       err = 32'h1;
    else if (wr && addr < 3)      err = 32'h2;
    else                          err = 32'h0;
    rdata = 32'h0;
    if (err == 0 && !wr) begin
      if (addr == 0)      rdata = ID_VALUE;
      else if (addr == 1) rdata = sts_in;
      else if (addr == 2) rdata = mdl_cnt;
      else                rdata = mdl_mem[addr];
    end
    if (mode == 0) begin
      e.rdata  = rdata;
      e.err    = err;
      e.strobe = (err == 0) && wr;
      e.waddr  = addr[7:0];
      if (e.strobe)
        mdl_mem[addr] = data;
      mdl_cnt = mdl_cnt + 1;
      e.cnt   = mdl_cnt;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    sc_port    = port;
    sc_addr    = addr;
    sc_subaddr = sub;
    sc_data    = data;
    sc_wr      = wr;
    sc_frame   = 1'b1;
    sc_op      = 1'b1;
    acks0 = acks;
    seen  = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mode == 2 && k == 3)
        sc_frame = 1'b0;
      if (mode == 3 && k == 3) begin
        sc_op    = 1'b0;
        sc_frame = 1'b0;
        rst      = 1'b1;
        #1;
        model_reset();
        chk("rst_ack", 32'(sc_ack), 32'h0);
        chk("rst_rdata", sc_rply_data, 32'h0);
        chk("rst_rerr", sc_rply_error, 32'h0);
        chk("rst_strobe", 32'(cfg_wr_strobe), 32'h0);
        chk("rst_waddr", 32'(cfg_wr_addr), 32'h0);
        check_regs("rst");
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (sc_ack) begin
        seen = 1;
        break;
      end
      if (mode == 1 && k == 20) break;
      if (mode == 2 && k == 12) break;
    end
    if (mode == 0) begin
      if (!seen) begin
        total++;
        $display("FAIL ack_timeout: no ack within 40 cycles, addr %h", addr);
      end else begin
        chk("ack_latency", 32'(k), 32'(ACK_LAT + 3));
      end
    end else if (mode == 1 || mode == 2) begin
      chk("no_ack", 32'(acks - acks0), 32'h0);
      check_regs(mode == 1 ? "port" : "abort");
    end
    sc_op    = 1'b0;
    sc_frame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;
    acks   = 0;
    model_reset();
    rst        = 1'b1;
    sc_port    = '0;
    sc_addr    = '0;
    sc_subaddr = '0;
    sc_data    = '0;
    sc_wr      = 1'b0;
    sc_op      = 1'b0;
    sc_frame   = 1'b0;
    sts_in     = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(sc_ack), 32'h0);
    chk("reset_rdata", sc_rply_data, 32'h0);
    chk("reset_rerr", sc_rply_error, 32'h0);
    chk("reset_strobe", 32'(cfg_wr_strobe), 32'h0);
    chk("reset_waddr", 32'(cfg_wr_addr), 32'h0);
    check_regs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_op(MY_PORT, 32'd3, 32'd0, 32'hDEAD_BEEF, 1'b1, 0);
    do_op(MY_PORT, 32'd3, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd0, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd1, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd2, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd16, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd1, 32'd0, 32'h5555_AAAA, 1'b1, 0);
    do_op(MY_PORT, 32'd16, 32'd1, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'h0000_0103, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT + 16'd1, 32'd3, 32'd0, 32'h0000_0005, 1'b1, 1);
    do_op(MY_PORT, 32'd4, 32'd0, 32'hCAFE_0004, 1'b1, 0);
    do_op(MY_PORT, 32'd4, 32'd0, 32'h0BAD_0004, 1'b1, 2);
    do_op(MY_PORT, 32'd4, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd5, 32'd0, 32'h1111_2222, 1'b1, 3);
    do_op(MY_PORT, 32'd3, 32'd0, 32'h0, 1'b0, 0);
    do_op(MY_PORT, 32'd5, 32'd0, 32'h3333_4444, 1'b1, 0);
    do_op(MY_PORT, 32'd5, 32'd0, 32'h0, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      int          r;
      int          mode;
      logic [31:0] addr;
      logic [31:0] sub;
      r      = $urandom_range(0, 9);
      addr   = 32'($urandom_range(0, 19));
      sub    = 32'h0;
      mode   = 0;
      sts_in = $urandom;
      if (r == 0) addr = {24'($urandom_range(1, 255)), addr[7:0]};
      if (r == 1) sub = 32'($urandom_range(1, 3));
      if (r == 2) mode = 1;
      if (r == 3) mode = 2;
      do_op((mode == 1) ? MY_PORT + 16'd2 : MY_PORT, addr, sub,
            $urandom, 1'($urandom_range(0, 1)), mode);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
